// File: rtl/aes_key_schedule_if.sv
// aes_key_schedule_if: start/key/read bus between the register file, key expander and decrypt core
interface aes_key_schedule_if;
  logic         start;
  logic [127:0] cipher_key;
  logic [3:0]   round_idx;
  logic [127:0] round_key;
  logic         busy;
  logic         done;
  modport master (output start, cipher_key, round_idx, input round_key, busy, done);
  modport slave  (input start, cipher_key, round_idx, output round_key, busy, done);
endinterface

// File: rtl/aes_key_schedule.sv
// aes_key_schedule: AES-128 key expansion, one round key per clock into a randomly readable buffer
module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = xtime(x);
    end
    return p;
  endfunction
  logic [7:0] inv;
  logic [7:0] sq;
  // Multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128 (maps 0 to 0)
  always_comb begin
    inv = 8'h01;
    sq  = a_i;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    s_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

module aes_key_schedule #(
  parameter int NUM_ROUNDS = 10
) (
  input logic               clk,
  input logic               rst_n,
  aes_key_schedule_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  state_t       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         busy_q, done_q;
  logic [127:0] key_buf [NUM_ROUNDS+1];
  logic [3:0]   prev_idx;
  logic [127:0] prev_key;
  logic [31:0]  rot_word, sub_word, temp_word;
  logic [31:0]  w0, w1, w2, w3;
  assign prev_idx  = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
  assign prev_key  = key_buf[prev_idx];
  assign rot_word  = {prev_key[23:0], prev_key[31:24]};
  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (.a_i(rot_word[8*i +: 8]), .s_o(sub_word[8*i +: 8]));
  end
  assign temp_word = sub_word ^ {rcon_q, 24'h0};
  assign w0 = prev_key[127:96] ^ temp_word;
  assign w1 = prev_key[95:64]  ^ w0;
  assign w2 = prev_key[63:32]  ^ w1;
  assign w3 = prev_key[31:0]   ^ w2;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rcon_d  = rcon_q;
    case (state_q)
      IDLE: begin
        state_d = bus.start ? EXPAND : IDLE;
        cnt_d   = bus.start ? 4'd1 : cnt_q;
        rcon_d  = bus.start ? 8'h01 : rcon_q;
      end
      EXPAND: begin
        cnt_d   = cnt_q + 4'd1;
        rcon_d  = xtime(rcon_q);
        state_d = (cnt_q == 4'(NUM_ROUNDS)) ? DONE : EXPAND;
      end
      DONE:    state_d = bus.start ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rcon_q  <= 8'h01;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rcon_q  <= rcon_d;
      busy_q  <= (state_d == EXPAND);
      done_q  <= (state_d == DONE);
    end
  end
  // Buffer has no reset: reads are masked until a full run has filled it
  always_ff @(posedge clk) begin
    if (state_q == IDLE && bus.start) key_buf[0] <= bus.cipher_key;
    else if (state_q == EXPAND) key_buf[cnt_q] <= {w0, w1, w2, w3};
  end
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.round_key = (done_q && bus.round_idx <= 4'(NUM_ROUNDS)) ? key_buf[bus.round_idx] : 128'h0;
endmodule

// File: tb/tb_aes_key_schedule.sv
// tb_aes_key_schedule: directed known-answer checks of AES-128 key expansion, control and reset behaviour
module tb_aes_key_schedule;
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] SEQ_R10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int total = 0;
  int passed = 0;
  aes_key_schedule_if ks ();
  aes_key_schedule dut (.clk(clk), .rst_n(rst_n), .bus(ks));
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  task automatic read_idx(input logic [3:0] i, output logic [127:0] k);
    ks.round_idx = i;
    #1;
    k = ks.round_key;
  endtask
  task automatic start_run(input logic [127:0] key, output int n);
    ks.cipher_key = key;
    ks.start = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!ks.done && n < 40);
  endtask
  task automatic end_run();
    ks.start = 1'b0;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    logic [127:0] k;
    #3 rst_n = 1'b0;
    #1;
    read_idx(4'd0, k);
    total++; if (ks.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", ks.busy); else passed++;
    total++; if (ks.done !== 1'b0) $display("FAIL reset_done got %b want 0", ks.done); else passed++;
    total++; if (k !== 128'h0) $display("FAIL reset_key got %h want 0", k); else passed++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  task automatic test_fips();
    int n;
    logic [127:0] k;
    start_run(FIPS_KEY, n);
    total++; if (n !== 11) $display("FAIL fips_latency got %0d want 11", n); else passed++;
    total++; if (ks.busy !== 1'b0) $display("FAIL fips_busy_at_done got %b want 0", ks.busy); else passed++;
    read_idx(4'd1, k);
    total++; if (k !== FIPS_R1) $display("FAIL fips_idx1 got %h want %h", k, FIPS_R1); else passed++;
    read_idx(4'd10, k);
    total++; if (k !== FIPS_R10) $display("FAIL fips_idx10 got %h want %h", k, FIPS_R10); else passed++;
    read_idx(4'd0, k);
    total++; if (k !== FIPS_KEY) $display("FAIL fips_idx0 got %h want %h", k, FIPS_KEY); else passed++;
    repeat (3) @(posedge clk);
    #1;
    total++; if (ks.done !== 1'b1) $display("FAIL fips_done_held got %b want 1", ks.done); else passed++;
    end_run();
    total++; if (ks.done !== 1'b0) $display("FAIL fips_done_drop got %b want 0", ks.done); else passed++;
    total++; if (ks.round_key !== 128'h0) $display("FAIL fips_key_after got %h want 0", ks.round_key); else passed++;
  endtask
  task automatic test_seq_key();
    int n;
    logic [127:0] k;
    start_run(SEQ_KEY, n);
    total++; if (n !== 11) $display("FAIL seq_latency got %0d want 11", n); else passed++;
    read_idx(4'd10, k);
    total++; if (k !== SEQ_R10) $display("FAIL seq_idx10 got %h want %h", k, SEQ_R10); else passed++;
    end_run();
  endtask
  task automatic test_zero_key();
    int n;
    logic [127:0] k;
    start_run(128'h0, n);
    read_idx(4'd1, k);
    total++; if (k !== ZERO_R1) $display("FAIL zero_idx1 got %h want %h", k, ZERO_R1); else passed++;
    read_idx(4'd10, k);
    total++; if (k !== ZERO_R10) $display("FAIL zero_idx10 got %h want %h", k, ZERO_R10); else passed++;
    end_run();
  endtask
  task automatic test_pulse();
    int n;
    logic [127:0] k;
    ks.cipher_key = FIPS_KEY;
    ks.start = 1'b1;
    @(posedge clk);
    #1;
    ks.start = 1'b0;
    ks.cipher_key = '1;
    n = 0;
    while (!ks.done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++; if (n !== 10) $display("FAIL pulse_latency got %0d want 10", n); else passed++;
    read_idx(4'd10, k);
    total++; if (k !== FIPS_R10) $display("FAIL pulse_idx10 got %h want %h", k, FIPS_R10); else passed++;
    read_idx(4'd0, k);
    total++; if (k !== FIPS_KEY) $display("FAIL pulse_idx0 got %h want %h", k, FIPS_KEY); else passed++;
    @(posedge clk);
    #1;
    total++; if (ks.done !== 1'b0) $display("FAIL pulse_done_one_cycle got %b want 0", ks.done); else passed++;
    total++; if (ks.round_key !== 128'h0) $display("FAIL pulse_key_after got %h want 0", ks.round_key); else passed++;
    repeat (3) @(posedge clk);
    #1;
    total++; if (ks.busy !== 1'b0) $display("FAIL pulse_no_restart got %b want 0", ks.busy); else passed++;
  endtask
  task automatic test_reset_mid();
    int n;
    logic [127:0] k;
    ks.cipher_key = 128'h0;
    ks.start = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    total++; if (ks.busy !== 1'b1) $display("FAIL mid_busy_before got %b want 1", ks.busy); else passed++;
    #1 rst_n = 1'b0;
    #1;
    total++; if (ks.busy !== 1'b0) $display("FAIL mid_busy_async got %b want 0", ks.busy); else passed++;
    total++; if (ks.done !== 1'b0) $display("FAIL mid_done_async got %b want 0", ks.done); else passed++;
    ks.start = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (ks.done !== 1'b0) $display("FAIL mid_done_idle got %b want 0", ks.done); else passed++;
    start_run(FIPS_KEY, n);
    total++; if (n !== 11) $display("FAIL mid_latency got %0d want 11", n); else passed++;
    read_idx(4'd1, k);
    total++; if (k !== FIPS_R1) $display("FAIL mid_idx1 got %h want %h", k, FIPS_R1); else passed++;
    read_idx(4'd10, k);
    total++; if (k !== FIPS_R10) $display("FAIL mid_idx10 got %h want %h", k, FIPS_R10); else passed++;
    for (int i = 11; i < 16; i++) begin
      read_idx(4'(i), k);
      total++; if (k !== 128'h0) $display("FAIL mid_idx%0d got %h want 0", i, k); else passed++;
    end
    end_run();
  endtask
  initial begin
    ks.start = 1'b0;
    ks.cipher_key = '0;
    ks.round_idx = '0;
    test_reset();
    test_fips();
    test_seq_key();
    test_zero_key();
    test_pulse();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
